// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: both requester handshakes plus the shared downstream SRAM-like port.
// slave is the arbiter's view; master is the view of the requesters and the downstream bridge.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req, m0_wr, m0_addr_ok, m0_data_ok;
    logic [1:0]    m0_size;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_wr, m1_addr_ok, m1_data_ok;
    logic [1:0]    m1_size;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]    s_size;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    modport slave (
        input  m0_req, m0_wr, m0_size, m0_addr, m0_wdata,
        output m0_addr_ok, m0_data_ok, m0_rdata,
        input  m1_req, m1_wr, m1_size, m1_addr, m1_wdata,
        output m1_addr_ok, m1_data_ok, m1_rdata,
        output s_req, s_wr, s_size, s_addr, s_wdata,
        input  s_addr_ok, s_data_ok, s_rdata
    );
    modport master (
        output m0_req, m0_wr, m0_size, m0_addr, m0_wdata,
        input  m0_addr_ok, m0_data_ok, m0_rdata,
        output m1_req, m1_wr, m1_size, m1_addr, m1_wdata,
        input  m1_addr_ok, m1_data_ok, m1_rdata,
        input  s_req, s_wr, s_size, s_addr, s_wdata,
        output s_addr_ok, s_data_ok, s_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master SRAM-like arbiter with an in-order owner-ID queue for response routing.
// Define ARB_ROUND_ROBIN_EN for round-robin grant; otherwise master 1 has fixed priority.
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic clk,
    input logic reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    logic [CW-1:0]              count;
    logic [PW-1:0]              rd_ptr, wr_ptr;
    logic [MAX_OUTSTANDING-1:0] q;
    logic                       lock_valid, lock_id, err;
    logic                       prio, g, mg_req, s_req, full, empty;
    logic                       accept, bypass, push, pop, head, resp;
    logic [AW-1:0]              addr_g;
    logic [DW-1:0]              wdata_g;
`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr;
    always_ff @(posedge clk or posedge reset)
        if (reset) rr_ptr <= 1'b1;
        else if (accept) rr_ptr <= ~g;
    assign prio = rr_ptr;
`else
    assign prio = 1'b1;
`endif
    assign g       = lock_valid ? lock_id : (bus.m0_req & bus.m1_req) ? prio : bus.m1_req;
    assign mg_req  = g ? bus.m1_req : bus.m0_req;
    assign full    = count == CW'(MAX_OUTSTANDING);
    assign empty   = count == '0;
    assign s_req   = ~reset & mg_req & ~full;
    assign accept  = s_req & bus.s_addr_ok;
    // An empty queue with a same-cycle accept and response routes straight to g.
    assign bypass  = empty & accept & bus.s_data_ok;
    assign push    = accept & ~bypass;
    assign pop     = bus.s_data_ok & ~empty;
    assign head    = empty ? g : q[rd_ptr];
    assign resp    = ~reset & bus.s_data_ok & (~empty | accept);
    assign addr_g  = g ? bus.m1_addr : bus.m0_addr;
    assign wdata_g = g ? bus.m1_wdata : bus.m0_wdata;
    assign bus.s_req      = s_req;
    assign bus.s_wr       = g ? bus.m1_wr : bus.m0_wr;
    assign bus.s_size     = g ? bus.m1_size : bus.m0_size;
    assign bus.s_addr     = addr_g;
    assign bus.s_wdata    = wdata_g;
    assign bus.m0_addr_ok = accept & ~g;
    assign bus.m1_addr_ok = accept & g;
    assign bus.m0_data_ok = resp & ~head;
    assign bus.m1_data_ok = resp & head;
    assign bus.m0_rdata   = bus.s_rdata;
    assign bus.m1_rdata   = bus.s_rdata;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            q          <= '0;
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (push) begin
                q[wr_ptr] <= g;
                wr_ptr    <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count      <= count + CW'(push) - CW'(pop);
            lock_valid <= s_req ? ~bus.s_addr_ok : lock_valid;
            lock_id    <= (s_req & ~bus.s_addr_ok) ? g : lock_id;
            // A response with nothing outstanding and no accept has no owner.
            err        <= err | (bus.s_data_ok & empty & ~accept);
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenario tasks for mem_bus_arbiter with hand-computed expectations.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();
    mem_bus_arbiter #(.AW(32), .DW(32), .MAX_OUTSTANDING(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic idle;
        bus.m0_req = 0; bus.m0_wr = 0; bus.m0_size = 2; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_wr = 0; bus.m1_size = 2; bus.m1_addr = 0; bus.m1_wdata = 0;
        bus.s_addr_ok = 0; bus.s_data_ok = 0; bus.s_rdata = 0;
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        idle;
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset;
        idle;
        reset = 1;
        bus.m0_req = 1; bus.m1_req = 1; bus.s_addr_ok = 1; bus.s_data_ok = 1;
        @(negedge clk);
        checks++;
        if ({bus.s_req, bus.m0_addr_ok, bus.m0_data_ok, bus.m1_addr_ok, bus.m1_data_ok} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000",
                     {bus.s_req, bus.m0_addr_ok, bus.m0_data_ok, bus.m1_addr_ok, bus.m1_data_ok});
        end
        checks++;
        if ({dut.count, dut.lock_valid, dut.err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_state count %0d lock %b err %b exp 0 0 0", dut.count, dut.lock_valid, dut.err);
        end
    endtask

    task automatic test_single_read;
        do_reset;
        bus.m0_req = 1; bus.m0_addr = 32'h1000;
        for (int c = 1; c <= 5; c++) begin
            bus.s_addr_ok = (c == 2);
            bus.s_data_ok = (c == 4);
            bus.s_rdata = (c == 4) ? 32'hDEADBEEF : 32'h0;
            if (c == 3) bus.m0_req = 0;
            @(negedge clk);
            checks++;
            if ({bus.m0_addr_ok, bus.m0_data_ok, bus.m1_addr_ok, bus.m1_data_ok} !== {c == 2, c == 4, 2'b00}) begin
                errors++;
                $display("FAIL single_ok c%0d got %b exp %b", c,
                         {bus.m0_addr_ok, bus.m0_data_ok, bus.m1_addr_ok, bus.m1_data_ok}, {c == 2, c == 4, 2'b00});
            end
            if (c == 2) begin
                checks++;
                if (bus.s_addr !== 32'h1000) begin
                    errors++;
                    $display("FAIL single_addr got %h exp 00001000", bus.s_addr);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.m0_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL single_rdata got %h exp deadbeef", bus.m0_rdata);
                end
            end
            next;
        end
    endtask

    task automatic test_contention;
        bit acc_at[16];
        bit q_own[$];
        bit own;
        bit exp_g;
        int cnt;
        int n_acc;
        do_reset;
        exp_g = 1; cnt = 0; n_acc = 0;
        foreach (acc_at[i]) acc_at[i] = 0;
        bus.m0_req = 1; bus.m0_addr = 32'h100;
        bus.m1_req = 1; bus.m1_addr = 32'h200;
        for (int c = 0; c < 12; c++) begin
            bus.s_addr_ok = 1;
            bus.s_data_ok = (c >= 3) ? acc_at[c - 3] : 1'b0;
            @(negedge clk);
            checks++;
            if (cnt == 2) begin
                if ({bus.s_req, bus.m1_addr_ok, bus.m0_addr_ok} !== 3'b000) begin
                    errors++;
                    $display("FAIL cont_stall c%0d got %b exp 000", c, {bus.s_req, bus.m1_addr_ok, bus.m0_addr_ok});
                end
            end else if ({bus.s_req, bus.m1_addr_ok, bus.m0_addr_ok, bus.s_addr} !==
                         {1'b1, exp_g, ~exp_g, exp_g ? 32'h200 : 32'h100}) begin
                errors++;
                $display("FAIL cont_grant c%0d got req %b ok1 %b ok0 %b addr %h exp grant %b",
                         c, bus.s_req, bus.m1_addr_ok, bus.m0_addr_ok, bus.s_addr, exp_g);
            end
            checks++;
            own = bus.s_data_ok ? q_own.pop_front() : 1'b0;
            if ({bus.m1_data_ok, bus.m0_data_ok} !== (bus.s_data_ok ? {own, ~own} : 2'b00)) begin
                errors++;
                $display("FAIL cont_route c%0d got %b exp owner %b valid %b",
                         c, {bus.m1_data_ok, bus.m0_data_ok}, own, bus.s_data_ok);
            end
            if (cnt != 2) begin
                acc_at[c] = 1;
                q_own.push_back(exp_g);
                n_acc++;
                cnt++;
`ifdef ARB_ROUND_ROBIN_EN
                exp_g = ~exp_g;
`endif
            end
            if (bus.s_data_ok) cnt--;
            next;
        end
        checks++;
        if (n_acc != 6) begin
            errors++;
            $display("FAIL cont_accepts got %0d exp 6", n_acc);
        end
        idle;
        do_reset;
    endtask

    task automatic test_lock;
        do_reset;
        bus.m0_req = 1; bus.m0_addr = 32'h3000; bus.m1_addr = 32'h4000;
        for (int c = 1; c <= 7; c++) begin
            bus.m1_req = (c >= 2 && c <= 5);
            if (c == 5) bus.m0_req = 0;
            bus.s_addr_ok = (c == 4 || c == 5);
            bus.s_data_ok = (c >= 6);
            @(negedge clk);
            if (c <= 5) begin
                checks++;
                if ({bus.s_addr, bus.m0_addr_ok, bus.m1_addr_ok} !==
                    {c == 5 ? 32'h4000 : 32'h3000, c == 4, c == 5}) begin
                    errors++;
                    $display("FAIL lock_addr c%0d got %h ok0 %b ok1 %b", c, bus.s_addr, bus.m0_addr_ok, bus.m1_addr_ok);
                end
            end else begin
                checks++;
                if ({bus.m0_data_ok, bus.m1_data_ok} !== {c == 6, c == 7}) begin
                    errors++;
                    $display("FAIL lock_route c%0d got %b exp %b", c, {bus.m0_data_ok, bus.m1_data_ok}, {c == 6, c == 7});
                end
            end
            next;
        end
        idle;
    endtask

    task automatic test_full;
        do_reset;
        bus.m0_req = 1; bus.m0_addr = 32'h5000;
        for (int c = 1; c <= 4; c++) begin
            bus.s_addr_ok = 1;
            bus.s_data_ok = (c == 3);
            @(negedge clk);
            checks++;
            if ({bus.s_req, bus.m0_addr_ok, bus.m0_data_ok} !== {c != 3, c != 3, c == 3}) begin
                errors++;
                $display("FAIL full_c%0d got req/aok/dok %b exp %b", c,
                         {bus.s_req, bus.m0_addr_ok, bus.m0_data_ok}, {c != 3, c != 3, c == 3});
            end
            if (c == 3) begin
                checks++;
                if (dut.count !== 2) begin
                    errors++;
                    $display("FAIL full_count got %0d exp 2", dut.count);
                end
            end
            next;
        end
        idle;
        @(negedge clk);
        checks++;
        if (dut.count !== 2) begin
            errors++;
            $display("FAIL full_resume_count got %0d exp 2", dut.count);
        end
        do_reset;
    endtask

    task automatic test_bypass;
        do_reset;
        bus.m1_req = 1; bus.m1_addr = 32'h6000; bus.s_addr_ok = 1; bus.s_data_ok = 1; bus.s_rdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if ({bus.s_req, bus.m1_addr_ok, bus.m1_data_ok, bus.m0_addr_ok, bus.m0_data_ok, bus.m1_rdata} !==
            {5'b11100, 32'h12345678}) begin
            errors++;
            $display("FAIL bypass_ok got %b rdata %h exp 11100 12345678",
                     {bus.s_req, bus.m1_addr_ok, bus.m1_data_ok, bus.m0_addr_ok, bus.m0_data_ok}, bus.m1_rdata);
        end
        next;
        idle;
        @(negedge clk);
        checks++;
        if ({dut.count, dut.err} !== 3'b0) begin
            errors++;
            $display("FAIL bypass_count got count %0d err %b exp 0 0", dut.count, dut.err);
        end
    endtask

    task automatic test_spurious;
        do_reset;
        bus.s_data_ok = 1;
        @(negedge clk);
        checks++;
        if ({bus.m0_data_ok, bus.m1_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL spurious_ok got %b exp 00", {bus.m0_data_ok, bus.m1_data_ok});
        end
        next;
        bus.s_data_ok = 0;
        @(negedge clk);
        checks++;
        if (dut.err !== 1'b1) begin
            errors++;
            $display("FAIL spurious_err got %b exp 1", dut.err);
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        bus.m1_req = 1; bus.m1_addr = 32'h7000; bus.s_addr_ok = 1;
        next;
        bus.s_data_ok = 1;
        @(negedge clk);
        checks++;
        if ({bus.s_req, bus.m1_addr_ok, bus.m1_data_ok, dut.count} !== {3'b111, 2'd1}) begin
            errors++;
            $display("FAIL areset_pre got %b count %0d exp 111 1",
                     {bus.s_req, bus.m1_addr_ok, bus.m1_data_ok}, dut.count);
        end
        #2 reset = 1;
        #1;
        checks++;
        if ({bus.s_req, bus.m0_addr_ok, bus.m0_data_ok, bus.m1_addr_ok, bus.m1_data_ok, dut.count} !== 7'b0) begin
            errors++;
            $display("FAIL areset_now got %b count %0d exp 00000 0",
                     {bus.s_req, bus.m0_addr_ok, bus.m0_data_ok, bus.m1_addr_ok, bus.m1_data_ok}, dut.count);
        end
        @(posedge clk);
        #1;
        reset = 0;
        idle;
        @(negedge clk);
        checks++;
        if ({dut.count, bus.s_req} !== 3'b0) begin
            errors++;
            $display("FAIL areset_after got count %0d req %b exp 0 0", dut.count, bus.s_req);
        end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_contention;
        test_lock;
        test_full;
        test_bypass;
        test_spurious;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
